// File: rtl/dmux4way_dispatcher_if.sv
// Producer/consumer bus of the 4-way demux dispatcher.
// The dispatcher uses the slave view; the producer/consumer side uses the master view.
interface dmux4way_dispatcher_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       sel;
    logic             busy;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, sel, busy
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, sel, busy
    );
endinterface

// File: rtl/dmux4way_dispatcher.sv
// Round-robin sequencer for the 4-way demux datapath.
// A one-word output register holds the word and its channel select.
// Each channel gets at most BURST consecutive words before the grant rotates.
module dmux4way_dispatcher #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [3:0]                  ch_en,
    dmux4way_dispatcher_if.slave        bus
);
    localparam int unsigned       CNT_W     = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST);
    localparam logic [CNT_W-1:0]  ONE_CNT   = CNT_W'(1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [3:0]       ovalid_q, ovalid_d;

    logic             drain_c;
    logic             accept_c;
    logic             in_ready_c;
    logic [1:0]       nxt_c;
    logic [CNT_W-1:0] nxt_beat_c;
    logic [1:0]       cand_c;
    logic             found_c;

    // Handshake decode: a drain frees the register for a same-cycle reload.
    always_comb begin
        drain_c    = (state_q == FULL) && bus.out_ready[sel_q];
        in_ready_c = reset_n && (|ch_en) && ((state_q == EMPTY) || drain_c);
        accept_c   = bus.in_valid && in_ready_c;
    end

    // Channel choice; beat_q==0 means no burst is open (after reset), so the scan starts at last+1.
    always_comb begin
        nxt_c      = last_q;
        nxt_beat_c = ONE_CNT;
        cand_c     = 2'd0;
        found_c    = 1'b0;
        if (ch_en[last_q] && (beat_q != '0) && (beat_q < BURST_CNT)) begin
            nxt_c      = last_q;
            nxt_beat_c = beat_q + ONE_CNT;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                cand_c = last_q + 2'(k);
                if (!found_c && ch_en[cand_c]) begin
                    nxt_c   = cand_c;
                    found_c = 1'b1;
                end
            end
        end
    end

    // Next-state and register loads for the EMPTY/FULL output buffer.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        last_d   = last_q;
        beat_d   = beat_q;
        ovalid_d = ovalid_q;

        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept_c) begin
                    state_d = FULL;
                end else if (drain_c) begin
                    state_d  = EMPTY;
                    ovalid_d = 4'b0000;
                end
            end
        endcase

        if (accept_c) begin
            data_d   = bus.in_data;
            sel_d    = nxt_c;
            last_d   = nxt_c;
            beat_d   = nxt_beat_c;
            ovalid_d = 4'b0001 << nxt_c;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            sel_q    <= 2'd0;
            last_q   <= 2'd3;
            beat_q   <= '0;
            ovalid_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
            ovalid_q <= ovalid_d;
        end
    end

    // Output drive: in_ready is the only combinational output.
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = ovalid_q;
        bus.out_data  = data_q;
        bus.sel       = sel_q;
        bus.busy      = (state_q == FULL);
    end
endmodule
